// File: rtl/snake_pkg.sv
// Shared definitions for the snake display path: cell object codes, RGB565
// palette, LCD command bytes and grid/cell geometry defaults.
package snake_pkg;

  typedef enum logic [2:0] {
    BLANK      = 3'd0,
    SNAKE_HEAD = 3'd1,
    SNAKE_BODY = 3'd2,
    APPLE_C    = 3'd3,
    BORDER_C   = 3'd4
  } obj_code_t;

  localparam logic [15:0] RGB_BLANK  = 16'h0000;
  localparam logic [15:0] RGB_HEAD   = 16'h03E0;
  localparam logic [15:0] RGB_BODY   = 16'h07E0;
  localparam logic [15:0] RGB_APPLE  = 16'hF800;
  localparam logic [15:0] RGB_BORDER = 16'h8410;
  localparam logic [15:0] RGB_OTHER  = 16'hF81F;
  localparam logic [15:0] RGB_GRID   = 16'h2104;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int CELL_W_DEF = 20;
  localparam int CELL_H_DEF = 20;
  localparam int GRID_X_DEF = 16;
  localparam int GRID_Y_DEF = 12;

  typedef enum logic [2:0] {
    IDLE, CASET_C, CASET_D, PASET_C, PASET_D, RAMWR_C, PIX, DONE
  } rstate_t;

  // Base fill colour of a cell; unnamed codes 5-7 show up as magenta.
  function automatic logic [15:0] code_rgb(input logic [2:0] code);
    logic [15:0] c;
    case (code)
      BLANK:      c = RGB_BLANK;
      SNAKE_HEAD: c = RGB_HEAD;
      SNAKE_BODY: c = RGB_BODY;
      APPLE_C:    c = RGB_APPLE;
      BORDER_C:   c = RGB_BORDER;
      default:    c = RGB_OTHER;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One 8080-style write cycle: wr_n low for a cycle with data/dc valid, then
// wr_n high with data/dc held. done is high in the second cycle so the
// controller can chain the next byte with no gap.
module lcd_byte_writer (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       dc,
  output logic       wr_n,
  output logic [7:0] data,
  output logic       dc_out,
  output logic       done
);

  // Strobe generator; data and dc stay put between bytes.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_n   <= 1'b1;
      data   <= 8'h00;
      dc_out <= 1'b1;
      done   <= 1'b0;
    end else if (start) begin
      wr_n   <= 1'b0;
      data   <= data_in;
      dc_out <= dc;
      done   <= 1'b0;
    end else begin
      wr_n   <= 1'b1;
      done   <= ~wr_n;
    end
  end

endmodule

// File: rtl/cell_renderer.sv
// Repaints one grid cell on an ILI9341-class LCD per accepted diff report:
// CASET/PASET window setup, RAMWR, then CELL_W*CELL_H RGB565 pixels.
// Build option CELL_RENDERER_GRID_EN: draws grid lines on the last column and
// last row of non-border cells.
module cell_renderer
  import snake_pkg::*;
#(
  parameter int CELL_W = CELL_W_DEF,
  parameter int CELL_H = CELL_H_DEF,
  parameter int GRID_X = GRID_X_DEF,
  parameter int GRID_Y = GRID_Y_DEF
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       diff,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] obj_code,
  output logic       ready,
  output logic       busy,
  output logic       lcd_cs_n,
  output logic       lcd_dc,
  output logic       lcd_wr_n,
  output logic [7:0] lcd_data
);

  localparam logic [8:0]  PIX_LAST = 9'(CELL_W * CELL_H - 1);
  localparam logic [15:0] CW16     = 16'(CELL_W);
  localparam logic [15:0] CH16     = 16'(CELL_H);

  rstate_t     state, nstate;
  logic [1:0]  sub, nsub;
  logic [8:0]  pix, npix;
  logic        hi, nhi;
  logic [3:0]  x_q, y_q;
  logic [2:0]  code_q;
  logic        start, wdc, done, accept, in_range, adv;
  logic [7:0]  wbyte;
  logic [15:0] x0, y0, cur_rgb, nxt_rgb;
  logic [31:0] wx, wy;

  assign ready    = (state == IDLE) || (state == DONE);
  assign busy     = (state != IDLE);
  assign lcd_cs_n = ready;
  assign accept   = ready && diff;
  assign in_range = ({1'b0, x} < 5'(GRID_X)) && ({1'b0, y} < 5'(GRID_Y));

  // Window edges, 16-bit so the far corner cell cannot wrap.
  assign x0 = 16'(x_q) * CW16;
  assign y0 = 16'(y_q) * CH16;
  assign wx = {x0, x0 + CW16 - 16'd1};
  assign wy = {y0, y0 + CH16 - 16'd1};

  function automatic logic [7:0] win_byte(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

`ifdef CELL_RENDERER_GRID_EN
  localparam logic [4:0] COL_LAST = 5'(CELL_W - 1);
  localparam logic [4:0] ROW_LAST = 5'(CELL_H - 1);
  logic [4:0] col, row, ncol, nrow;

  function automatic logic [15:0] grid_rgb(input logic [2:0] code,
                                           input logic [4:0] c, input logic [4:0] r);
    logic [15:0] v;
    v = code_rgb(code);
    if (code < BORDER_C && (c == COL_LAST || r == ROW_LAST))
      v = RGB_GRID;
    return v;
  endfunction

  assign ncol    = (col == COL_LAST) ? 5'd0 : col + 5'd1;
  assign nrow    = (col == COL_LAST) ? row + 5'd1 : row;
  assign cur_rgb = grid_rgb(code_q, col, row);
  assign nxt_rgb = grid_rgb(code_q, ncol, nrow);

  // Column/row position of the pixel currently on the bus.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      col <= 5'd0;
      row <= 5'd0;
    end else if (accept) begin
      col <= 5'd0;
      row <= 5'd0;
    end else if (adv) begin
      col <= ncol;
      row <= nrow;
    end
  end
`else
  assign cur_rgb = code_rgb(code_q);
  assign nxt_rgb = cur_rgb;
`endif

  // Latch the cell report on accept.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x_q    <= 4'd0;
      y_q    <= 4'd0;
      code_q <= 3'd0;
    end else if (accept) begin
      x_q    <= x;
      y_q    <= y;
      code_q <= obj_code;
    end
  end

  // State and byte/pixel counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      sub   <= 2'd0;
      pix   <= 9'd0;
      hi    <= 1'b0;
    end else begin
      state <= nstate;
      sub   <= nsub;
      pix   <= npix;
      hi    <= nhi;
    end
  end

  // Next-state and next-byte selection; a new byte launches as the previous
  // one finishes its hold cycle.
  always_comb begin
    nstate = state;
    nsub   = sub;
    npix   = pix;
    nhi    = hi;
    start  = 1'b0;
    wbyte  = 8'h00;
    wdc    = 1'b1;
    adv    = 1'b0;
    case (state)
      IDLE, DONE: begin
        nstate = IDLE;
        if (accept && in_range) begin
          nstate = CASET_C;
          nsub   = 2'd0;
          npix   = 9'd0;
          start  = 1'b1;
          wbyte  = CMD_CASET;
          wdc    = 1'b0;
        end
      end
      CASET_C: if (done) begin
        nstate = CASET_D;
        nsub   = 2'd0;
        start  = 1'b1;
        wbyte  = win_byte(wx, 2'd0);
      end
      CASET_D: if (done) begin
        start = 1'b1;
        if (sub == 2'd3) begin
          nstate = PASET_C;
          wbyte  = CMD_PASET;
          wdc    = 1'b0;
        end else begin
          nsub  = sub + 2'd1;
          wbyte = win_byte(wx, sub + 2'd1);
        end
      end
      PASET_C: if (done) begin
        nstate = PASET_D;
        nsub   = 2'd0;
        start  = 1'b1;
        wbyte  = win_byte(wy, 2'd0);
      end
      PASET_D: if (done) begin
        start = 1'b1;
        if (sub == 2'd3) begin
          nstate = RAMWR_C;
          wbyte  = CMD_RAMWR;
          wdc    = 1'b0;
        end else begin
          nsub  = sub + 2'd1;
          wbyte = win_byte(wy, sub + 2'd1);
        end
      end
      RAMWR_C: if (done) begin
        nstate = PIX;
        npix   = 9'd0;
        nhi    = 1'b1;
        start  = 1'b1;
        wbyte  = cur_rgb[15:8];
      end
      PIX: if (done) begin
        if (hi) begin
          nhi   = 1'b0;
          start = 1'b1;
          wbyte = cur_rgb[7:0];
        end else if (pix == PIX_LAST) begin
          nstate = DONE;
        end else begin
          npix  = pix + 9'd1;
          nhi   = 1'b1;
          adv   = 1'b1;
          start = 1'b1;
          wbyte = nxt_rgb[15:8];
        end
      end
      default: nstate = IDLE;
    endcase
  end

  lcd_byte_writer u_wr (
    .clk     (clk),
    .nrst    (nrst),
    .start   (start),
    .data_in (wbyte),
    .dc      (wdc),
    .wr_n    (lcd_wr_n),
    .data    (lcd_data),
    .dc_out  (lcd_dc),
    .done    (done)
  );

endmodule

// File: tb/tb_cell_renderer.sv
// Directed bench for cell_renderer: reset, single update, out-of-range drop,
// back-to-back with the corner cell, and reset in the middle of the pixel run.
module tb_cell_renderer;

  logic       clk = 1'b0;
  logic       nrst;
  logic       diff;
  logic [3:0] x, y;
  logic [2:0] obj_code;
  logic       ready, busy, lcd_cs_n, lcd_dc, lcd_wr_n;
  logic [7:0] lcd_data;

  int checks   = 0;
  int failures = 0;

  cell_renderer dut (
    .clk      (clk),
    .nrst     (nrst),
    .diff     (diff),
    .x        (x),
    .y        (y),
    .obj_code (obj_code),
    .ready    (ready),
    .busy     (busy),
    .lcd_cs_n (lcd_cs_n),
    .lcd_dc   (lcd_dc),
    .lcd_wr_n (lcd_wr_n),
    .lcd_data (lcd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Expected pixel colour for pixel index p of a cell.
  function automatic logic [15:0] exp_pix(input int p, input logic [15:0] c, input logic [2:0] code);
    logic g;
    g = 1'b0;
`ifdef CELL_RENDERER_GRID_EN
    g = 1'b1;
`endif
    if (g && code < 3'd4 && ((p % 20) == 19 || (p / 20) == 19)) return 16'h2104;
    return c;
  endfunction

  // Check the 1622 bus cycles of one transaction; called on the first
  // negedge after the accept edge, returns on the negedge of the last cycle.
  task automatic run_body(input string tag, input logic [87:0] hdr,
                          input logic [15:0] colr, input logic [2:0] code);
    int bad = 0, badctl = 0, first = -1, b, p;
    logic [7:0]  eb;
    logic        edc;
    logic [15:0] pc;
    for (int i = 0; i < 1622; i++) begin
      if (i > 0) @(negedge clk);
      b = i / 2;
      if (b < 11) begin
        eb  = hdr[87 - 8*b -: 8];
        edc = !(b == 0 || b == 5 || b == 10);
      end else begin
        p   = (b - 11) / 2;
        pc  = exp_pix(p, colr, code);
        eb  = (((b - 11) % 2) == 0) ? pc[15:8] : pc[7:0];
        edc = 1'b1;
      end
      if (lcd_wr_n !== ((i % 2) == 1) || lcd_data !== eb || lcd_dc !== edc) begin
        bad++;
        if (first < 0) first = i;
      end
      if (lcd_cs_n !== 1'b0 || ready !== 1'b0 || busy !== 1'b1) badctl++;
    end
    check({tag, "_bytes"}, 32'(bad), 32'd0);
    check({tag, "_first_bad_cycle"}, 32'(first), 32'hFFFF_FFFF);
    check({tag, "_ctl_low"}, 32'(badctl), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cs_n"}, 32'(lcd_cs_n), 32'd1);
    check({tag, "_wr_n"}, 32'(lcd_wr_n), 32'd1);
  endtask

  initial begin
    int quiet;
    nrst = 1'b0; diff = 1'b0; x = 4'd0; y = 4'd0; obj_code = 3'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    check("rst_data", 32'(lcd_data), 32'h00);
    check("rst_dc", 32'(lcd_dc), 32'd1);
    nrst = 1'b1;
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (lcd_wr_n !== 1'b1 || lcd_cs_n !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) quiet++;
    end
    check("post_rst_quiet", 32'(quiet), 32'd0);

    // Single update: x=3, y=2, apple
    diff = 1'b1; x = 4'd3; y = 4'd2; obj_code = 3'd3;
    @(negedge clk);
    diff = 1'b0;
    run_body("single", 88'h2A_00_3C_00_4F_2B_00_28_00_3B_2C, 16'hF800, 3'd3);
    @(negedge clk);
    check("single_done_ready", 32'(ready), 32'd1);
    check("single_done_cs_n", 32'(lcd_cs_n), 32'd1);
    check("single_done_busy", 32'(busy), 32'd1);
    check("single_done_wr_n", 32'(lcd_wr_n), 32'd1);
    @(negedge clk);
    check_idle_outputs("single_idle");

    // Out-of-range report is dropped
    diff = 1'b1; x = 4'd15; y = 4'd12; obj_code = 3'd1;
    @(negedge clk);
    diff = 1'b0;
    quiet = 0;
    repeat (8) begin
      if (lcd_wr_n !== 1'b1 || lcd_cs_n !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) quiet++;
      @(negedge clk);
    end
    check("oor_quiet", 32'(quiet), 32'd0);

    // Back-to-back: new report held on diff while busy, then corner cell
    diff = 1'b1; x = 4'd3; y = 4'd2; obj_code = 3'd3;
    @(negedge clk);
    x = 4'd15; y = 4'd11; obj_code = 3'd4;
    run_body("b2b_first", 88'h2A_00_3C_00_4F_2B_00_28_00_3B_2C, 16'hF800, 3'd3);
    @(negedge clk);
    check("b2b_done_ready", 32'(ready), 32'd1);
    check("b2b_done_cs_n", 32'(lcd_cs_n), 32'd1);
    @(negedge clk);
    diff = 1'b0;
    run_body("corner", 88'h2A_01_2C_01_3F_2B_00_DC_00_EF_2C, 16'h8410, 3'd4);
    @(negedge clk);
    check("corner_done_ready", 32'(ready), 32'd1);
    @(negedge clk);
    check_idle_outputs("corner_idle");

    // Reset in the middle of the pixel run (past pixel 100)
    diff = 1'b1; x = 4'd0; y = 4'd0; obj_code = 3'd1;
    @(negedge clk);
    diff = 1'b0;
    repeat (430) @(negedge clk);
    check("midpix_busy", 32'(busy), 32'd1);
    nrst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    check("midrst_data", 32'(lcd_data), 32'h00);
    check("midrst_dc", 32'(lcd_dc), 32'd1);
    quiet = 0;
    repeat (3) begin
      @(negedge clk);
      if (lcd_wr_n !== 1'b1 || lcd_cs_n !== 1'b1) quiet++;
    end
    check("midrst_hold_quiet", 32'(quiet), 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    diff = 1'b1; x = 4'd1; y = 4'd1; obj_code = 3'd2;
    @(negedge clk);
    diff = 1'b0;
    run_body("after_rst", 88'h2A_00_14_00_27_2B_00_14_00_27_2C, 16'h07E0, 3'd2);
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("after_rst_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cell_renderer.md
Name: cell_renderer

Overview:
- Consumes changed-cell reports (x, y, obj_code, diff) from the grid scanner and repaints that 20x20-pixel cell on a 320x240 ILI9341-class LCD.
- The LCD is driven over an 8080-style 8-bit write-only parallel bus.
- Back-pressures the scanner through `ready`, which the top level wires to the scanner's `enable`.
- Sits between the frame/diff tracker and the LCD pins.

Parameters:
- CELL_W, 20, cell width in pixels.
- CELL_H, 20, cell height in pixels.
- GRID_X, 16, number of cell columns.
- GRID_Y, 12, number of cell rows.

Ports:
- clk  input  1  system clock
- nrst  input  1  reset, asynchronous, active-low
- diff  input  1  cell update valid (scanner's diff)
- x  input  4  cell column
- y  input  4  cell row
- obj_code  input  3  obj_code_t of the cell
- ready  output  1  high = able to accept; scanner advances only while high
- busy  output  1  high while an LCD transaction is in progress
- lcd_cs_n  output  1  chip select, active-low
- lcd_dc  output  1  0 = command byte, 1 = data byte
- lcd_wr_n  output  1  write strobe; LCD latches on rising edge
- lcd_data  output  8  bus data

Behaviour:
- Reset values: ready=1, busy=0, lcd_cs_n=1, lcd_dc=1, lcd_wr_n=1, lcd_data=0, state=IDLE.
- Reset mid-transaction aborts immediately; no partial byte completes afterward.
- Handshake:
  - Accept occurs in a cycle where ready=1 and diff=1.
  - On accept, x, y and obj_code are registered.
  - ready falls on the next edge and stays 0 until the transaction completes.
- Range check: if x>=GRID_X or y>=GRID_Y, the report is dropped. ready stays 1 and no bus activity occurs.
- Colour (RGB565) from the registered code:
  - blank 0x0000
  - snake_head 0x03E0
  - snake_body 0x07E0
  - apple_c 0xF800
  - border_c 0x8410
  - codes 5-7 0xF81F
- Window: x0=x*CELL_W, x1=x0+CELL_W-1, y0=y*CELL_H, y1=y0+CELL_H-1. All 16-bit, sent MSB byte first.
- Byte timing: each byte takes 2 cycles.
  - Phase 0: lcd_wr_n=0, lcd_data and lcd_dc valid.
  - Phase 1: lcd_wr_n=1, data and dc held.
- FSM:
  - IDLE: cs_n=1. On accept of an in-range report, go to CASET_C.
  - CASET_C: command 0x2A (dc=0), then CASET_D.
  - CASET_D: 4 data bytes x0H, x0L, x1H, x1L, then PASET_C.
  - PASET_C: command 0x2B, then PASET_D.
  - PASET_D: 4 data bytes y0H, y0L, y1H, y1L, then RAMWR_C.
  - RAMWR_C: command 0x2C, then PIX.
  - PIX: CELL_W*CELL_H pixels, each as colour high byte then low byte. The pixel counter is 9 bits and stops at 399. Then DONE.
  - DONE: one cycle with cs_n=1, ready=1, then IDLE.
- lcd_cs_n is 0 from the first CASET_C cycle through the last PIX cycle.
- busy = (state != IDLE).
- Latency:
  - First wr_n falling edge is 1 cycle after accept.
  - A full transaction is 811 bytes = 1622 cycles.
  - ready returns 1623 cycles after the accept edge; the next accept is possible in that same cycle.
- diff while ready=0 is ignored. The scanner is stalled, so the report is re-presented when ready returns.
- Boundary cells (x=15, y=11): x1=319, y1=239. No overflow is permitted; the window arithmetic is 16-bit.

Optional Feature:
- CELL_RENDERER_GRID_EN defined:
  - For non-border codes (0-3), pixels in the last column (col==CELL_W-1) or last row (row==CELL_H-1) of the cell use 0x2104 instead of the code colour.
  - Requires separate 5-bit column and row counters.
- Not defined: every pixel uses the code colour. Only the flat pixel counter is needed.

Decomposition:
- Shared package snake_pkg:
  - obj_code_t enum (moved out of the tracker)
  - RGB565 colour constants
  - LCD command constants CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C
  - GRID/CELL defaults
- Sub-module lcd_byte_writer:
  - Inputs: start, byte, dc.
  - Outputs: wr_n, data, dc_out, done.
  - Implements the 2-cycle strobe; the FSM steps on done.

Test Plan:
- Reset: hold nrst=0 → ready=1, busy=0, cs_n=1, wr_n=1, data=0. Release nrst → no bus activity while diff=0.
- Single update (diff=1, x=3, y=2, code=apple_c) → bytes 2A,00,3C,00,4F,2B,00,28,00,3B,2C, then 400x(F8,00). dc=0 only on the 3 command bytes. ready low for exactly 1622 cycles.
- Corner cell (x=15, y=11, code=border_c) → CASET 01,2C,01,3F; PASET 00,DC,00,EF; pixels 84,10.
- Out-of-range (x=4'd15, y=4'd12) → ready stays 1, cs_n stays 1, no wr_n edge.
- Back-to-back: diff held high with new x/y while busy → ignored until ready=1; second transaction starts the cycle after ready returns.
- Reset mid-PIX (after pixel 100) → all outputs return to reset values asynchronously; next accept starts a fresh CASET. With CELL_RENDERER_GRID_EN, pixels 19,39,…,399 and 380-399 read 21,04.
